// File: rtl/espsid_pkg.sv
// Shared types for the SID bus writer: bus widths, write-cycle FSM states and
// the buffered write-request format.
package espsid_pkg;

  localparam int SID_ADDR_W = 5;
  localparam int SID_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RELEASE
  } sid_state_e;

  typedef struct packed {
    logic [SID_ADDR_W-1:0] addr;
    logic [SID_DATA_W-1:0] data;
  } sid_wr_req_t;

  localparam int SID_REQ_W = $bits(sid_wr_req_t);

endpackage

// File: rtl/sid_write_fifo.sv
// Synchronous request FIFO with registered occupancy; read data is the current head,
// so a pop only ever consumes an entry that was already stored.
module sid_write_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             empty_nxt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_push   = push && !full;
    do_pop    = pop && !empty;
    wr_ptr_d  = wr_ptr_q + AW'(do_push);
    rd_ptr_d  = rd_ptr_q + AW'(do_pop);
    count_d   = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    empty_nxt = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/sid_bus_writer.sv
// Generates the SID phase-2 clock and SID reset, and turns buffered register writes
// into bus cycles: IDLE -> SETUP (addr/data out) -> STROBE (cs_n low) -> HOLD -> RELEASE.
module sid_bus_writer
  import espsid_pkg::*;
#(
  parameter int CLK_DIV    = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int RES_CYCLES = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [SID_ADDR_W-1:0] wr_addr,
  input  logic [SID_DATA_W-1:0] wr_data,
  output logic                  sid_clk,
  output logic                  sid_res_n,
  output logic                  sid_cs_n,
  output logic                  sid_rw,
  output logic [SID_ADDR_W-1:0] sid_addr,
  output logic [SID_DATA_W-1:0] sid_data,
  output logic                  sid_data_oe,
  output logic                  busy
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int RW = $clog2(RES_CYCLES + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [RW-1:0] RES_LAST = RW'(RES_CYCLES - 1);

  logic [DW-1:0]         div_cnt_q, div_cnt_d;
  logic                  sid_clk_q, sid_clk_d;
  logic [RW-1:0]         res_cnt_q, res_cnt_d;
  logic                  sid_res_n_q, sid_res_n_d;
  logic                  run_q;
  sid_state_e            state_q, state_d;
  logic                  sid_cs_n_q, sid_cs_n_d;
  logic                  sid_rw_q, sid_rw_d;
  logic [SID_ADDR_W-1:0] sid_addr_q, sid_addr_d;
  logic [SID_DATA_W-1:0] sid_data_q, sid_data_d;
  logic                  sid_data_oe_q, sid_data_oe_d;
  logic                  busy_q, busy_d;

  logic        div_wrap, rise_evt, fall_evt;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_empty_nxt;
  sid_wr_req_t req_in, head;

  assign req_in.addr = wr_addr;
  assign req_in.data = wr_data;
  assign wr_ready    = run_q && !fifo_full;
  assign fifo_push   = wr_valid && wr_ready;

  sid_write_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SID_REQ_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .din       (req_in),
    .dout      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .empty_nxt (fifo_empty_nxt)
  );

  // rise_evt/fall_evt mark the edge on which sid_clk changes, so bus outputs move with it.
  always_comb begin
    div_wrap  = (div_cnt_q == DIV_LAST);
    div_cnt_d = div_wrap ? '0 : div_cnt_q + DW'(1);
    sid_clk_d = sid_clk_q ^ div_wrap;
    rise_evt  = div_wrap && !sid_clk_q;
    fall_evt  = div_wrap && sid_clk_q;

    res_cnt_d   = res_cnt_q;
    sid_res_n_d = sid_res_n_q;
    if (fall_evt && !sid_res_n_q) begin
      if (res_cnt_q == RES_LAST) sid_res_n_d = 1'b1;
      else                       res_cnt_d   = res_cnt_q + RW'(1);
    end
  end

  always_comb begin
    state_d       = state_q;
    sid_cs_n_d    = sid_cs_n_q;
    sid_rw_d      = sid_rw_q;
    sid_addr_d    = sid_addr_q;
    sid_data_d    = sid_data_q;
    sid_data_oe_d = sid_data_oe_q;
    fifo_pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && sid_res_n_q && fall_evt) begin
          fifo_pop      = 1'b1;
          sid_addr_d    = head.addr;
          sid_data_d    = head.data;
          sid_rw_d      = 1'b0;
          sid_data_oe_d = 1'b1;
          state_d       = SETUP;
        end
      end
      SETUP: begin
        if (rise_evt) begin
          sid_cs_n_d = 1'b0;
          state_d    = STROBE;
        end
      end
      STROBE: begin
        if (fall_evt) state_d = HOLD;
      end
      HOLD: begin
        sid_cs_n_d = 1'b1;
        state_d    = RELEASE;
      end
      RELEASE: begin
        sid_data_oe_d = 1'b0;
        sid_rw_d      = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) || !fifo_empty_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt_q     <= '0;
      sid_clk_q     <= 1'b0;
      res_cnt_q     <= '0;
      sid_res_n_q   <= 1'b0;
      run_q         <= 1'b0;
      state_q       <= IDLE;
      sid_cs_n_q    <= 1'b1;
      sid_rw_q      <= 1'b1;
      sid_addr_q    <= '0;
      sid_data_q    <= '0;
      sid_data_oe_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      sid_clk_q     <= sid_clk_d;
      res_cnt_q     <= res_cnt_d;
      sid_res_n_q   <= sid_res_n_d;
      run_q         <= 1'b1;
      state_q       <= state_d;
      sid_cs_n_q    <= sid_cs_n_d;
      sid_rw_q      <= sid_rw_d;
      sid_addr_q    <= sid_addr_d;
      sid_data_q    <= sid_data_d;
      sid_data_oe_q <= sid_data_oe_d;
      busy_q        <= busy_d;
    end
  end

  assign sid_clk     = sid_clk_q;
  assign sid_res_n   = sid_res_n_q;
  assign sid_cs_n    = sid_cs_n_q;
  assign sid_rw      = sid_rw_q;
  assign sid_addr    = sid_addr_q;
  assign sid_data    = sid_data_q;
  assign sid_data_oe = sid_data_oe_q;
  assign busy        = busy_q;

endmodule

// File: doc/sid_bus_writer.md
# sid_bus_writer

Converts buffered SID register-write requests into correctly timed 6581/8580 bus cycles and generates the SID phase-2 clock. Sits between the host-command decoder (upstream valid/ready source) and the physical SID pins inside `espSID_top`. It owns `sid_clk`, so every SID bus transaction is phase-locked to the clock it produces. It also sequences the SID hardware reset after system reset.

## Interface
- `CLK_DIV`, 8: `clk` cycles per `sid_clk` half-period; must be ≥2.
- `FIFO_DEPTH`, 4: write-request buffer entries; must be a power of 2.
- `RES_CYCLES`, 10: `sid_clk` periods `sid_res_n` is held low after reset.

- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `wr_valid`  in  1  write request present.
- `wr_ready`  out  1  request accepted on a cycle where `wr_valid` and `wr_ready` are both high.
- `wr_addr`  in  5  SID register address.
- `wr_data`  in  8  register value.
- `sid_clk`  out  1  phase-2 clock to the SID.
- `sid_res_n`  out  1  SID reset.
- `sid_cs_n`  out  1  chip select.
- `sid_rw`  out  1  1 = read/idle, 0 = write.
- `sid_addr`  out  5  address bus.
- `sid_data`  out  8  data bus value.
- `sid_data_oe`  out  1  data bus drive enable.
- `busy`  out  1  FSM not in IDLE, or FIFO not empty.

## Operation
- Reset values, applied while `rst` is 0:
  - `sid_clk` 0, `sid_res_n` 0, `sid_cs_n` 1, `sid_rw` 1.
  - `sid_addr` 0, `sid_data` 0, `sid_data_oe` 0, `wr_ready` 0, `busy` 0.
  - FIFO flushed, divider counter 0, FSM in IDLE.
- Divider: counter `div_cnt` runs 0..CLK_DIV-1. At `div_cnt`==CLK_DIV-1, `sid_clk` toggles on the next edge. This gives `rise_evt` and `fall_evt`, each one cycle wide, registered at the edge where `sid_clk` changes.
- Reset sequencer: counts `sid_clk` falling edges after `rst` deasserts. `sid_res_n` goes high on the edge of the RES_CYCLES-th falling edge. No bus cycle starts while `sid_res_n` is 0. The FIFO still accepts requests during this time.
- FIFO:
  - `wr_ready` = not full (and not in reset).
  - A push and a pop in the same cycle are both honoured.
  - A pop acts only on entries present at the start of the cycle. There is no fall-through.
- FSM:
  - IDLE: when FIFO non-empty, `sid_res_n`=1 and `fall_evt`, pop the head. Load `sid_addr`/`sid_data`, set `sid_rw`=0 and `sid_data_oe`=1, then go to SETUP. The outputs change on the same edge `sid_clk` falls.
  - SETUP: on `rise_evt`, set `sid_cs_n`=0 and go to STROBE.
  - STROBE: on `fall_evt`, go to HOLD. `cs_n` stays low across the SID latching edge.
  - HOLD: one cycle, then set `sid_cs_n`=1 and go to RELEASE.
  - RELEASE: one cycle, then set `sid_data_oe`=0 and `sid_rw`=1 and go to IDLE. `sid_addr`/`sid_data` keep their last values.
- Reset mid-cycle: the next edge forces all reset values. An in-flight write is abandoned, and `cs_n` rises without completing the cycle.

## Timing
- `sid_clk` period is 2·CLK_DIV `clk` cycles.
- `sid_cs_n` is low for exactly CLK_DIV+1 cycles. It falls on the same edge `sid_clk` rises and rises 1 cycle after `sid_clk` falls.
- Address and data are stable from CLK_DIV cycles before `cs_n` falls until 1 cycle after `cs_n` rises.
- Latency from accept to the start of a bus cycle is 1 cycle to FIFO visibility, then up to 2·CLK_DIV cycles waiting for `fall_evt`.
- Throughput is one write per 2 `sid_clk` periods. After RELEASE the FSM waits for the next-but-one falling edge.
- `busy` is registered and updates on the same edge as the FSM and FIFO count.

## Structure
- Shared package `espsid_pkg` holds:
  - `SID_ADDR_W`=5 and `SID_DATA_W`=8.
  - FSM state enum {IDLE, SETUP, STROBE, HOLD, RELEASE}.
  - Packed write-request type {addr, data}.
- Sub-module `sid_write_fifo`: synchronous FIFO parameterised by depth and width, with full/empty outputs. Everything else lives in `sid_bus_writer`.

## Test plan
All scenarios use a 10 ns `clk`, CLK_DIV=8, RES_CYCLES=10.
- Reset release: `rst` 0→1. `sid_clk` toggles every 8 cycles. `sid_res_n` rises on the 10th `sid_clk` falling edge, which is 160 cycles after release. All other outputs hold reset values throughout.
- Single write: push (0x18, 0x0F) after `sid_res_n`=1. On the next `sid_clk` fall, `sid_addr`=0x18, `sid_data`=0x0F, `oe`=1, `rw`=0. `cs_n` is low for 9 cycles starting at the `sid_clk` rise. `oe`=0 and `rw`=1 one cycle after `cs_n` rises.
- Early writes: push 2 requests during the `sid_res_n`=0 window. No `cs_n` activity before `sid_res_n` rises. After it, both writes appear in order, 2 `sid_clk` periods apart.
- Back-pressure: hold `wr_valid` high with 6 distinct requests. `wr_ready` drops after 4 accepted (FIFO full, plus 1 if a pop coincides). All 6 eventually appear on the bus in order, none lost or duplicated.
- Reset mid-write: assert `rst`=0 while in STROBE. On the next edge `cs_n`=1, `oe`=0, `sid_clk`=0, `sid_res_n`=0, and the FIFO is empty. After release, no stale write appears.
